// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing
// for a shared single-ALU, single-memory datapath, with memory wait timeout.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    EXEC_I   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_SW   = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_SLTI = 6'b000100;
  localparam logic [5:0] OP_ANDI = 6'b000101;
  localparam logic [5:0] OP_ORI  = 6'b000110;
  localparam logic [5:0] OP_BEQ  = 6'b000111;
  localparam logic [5:0] OP_BNE  = 6'b001000;
  localparam logic [5:0] OP_JMP  = 6'b001001;

  state_t     curState;
  state_t     nextState;
  logic [5:0] opQ;
  logic [3:0] waitCnt;
  logic       memWait;
  logic       timeout;

  assign memWait = (curState inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready;
  assign timeout = memWait && (waitCnt == 4'(WAIT_MAX - 1));

  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:    nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_R:                              nextState = EXEC_R;
          OP_SW, OP_LW:                      nextState = MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nextState = EXEC_I;
          OP_BEQ, OP_BNE:                    nextState = BRANCH;
          OP_JMP:                            nextState = JUMP;
          default:                           nextState = FETCH;
        endcase
      end
      MEM_ADDR: nextState = (opQ == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   nextState = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   nextState = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   nextState = R_WB;
      EXEC_I:   nextState = I_WB;
      default:  nextState = FETCH;
    endcase
  end

  // Timeout overrides the normal transition: a stalled memory state falls back to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curState <= FETCH;
      waitCnt  <= '0;
      opQ      <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (curState == DECODE) opQ <= op;
      if (timeout) begin
        curState <= FETCH;
        waitCnt  <= '0;
        bus_err  <= 1'b1;
      end else begin
        curState <= nextState;
        waitCnt  <= memWait ? waitCnt + 4'd1 : '0;
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state      = rst_n ? curState : 4'd0;
    if (rst_n) begin
      case (curState)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = 3'b001;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = 2'b11;
          alu_op     = 3'b001;
          illegal_op = !(op inside {OP_R, OP_SW, OP_LW, OP_ADDI, OP_SLTI,
                                    OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_JMP});
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'b001;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        EXEC_R: alu_src_a = 1'b1;
        R_WB: begin
          reg_write  = 1'b1;
          reg_dest   = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (opQ)
            OP_SLTI: alu_op = 3'b101;
            OP_ANDI: alu_op = 3'b011;
            OP_ORI:  alu_op = 3'b100;
            default: alu_op = 3'b001;
          endcase
        end
        I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 3'b010;
          pc_src     = 2'b01;
          instr_done = 1'b1;
          pc_write   = ((opQ == OP_BEQ) && zero) || ((opQ == OP_BNE) && !zero);
        end
        JUMP: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that sequences the shared single-ALU, single-memory datapath one instruction at a time. It replaces per-instruction combinational decode with a Moore state machine: fetch, decode, execute, memory, writeback. It handles memory wait states through a ready handshake, enforces a wait timeout, and reports completion and illegal opcodes. The opcode map is the team's existing 6-bit encoding.

## Interface
- WAIT_MAX, 8, max consecutive cycles a memory state waits with mem_ready low before abort (≥2)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  6  IR[31:26], valid from the DECODE cycle onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- i_or_d  out  1  0 PC addresses memory, 1 ALUOut addresses memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dest  out  1  1 rd, 0 rt
- mem_to_reg  out  1  1 MDR, 0 ALUOut to register file
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  3  000 R-type/funct, 001 add, 010 sub, 011 and, 100 or, 101 slt
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse on the final cycle of a retired instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unmapped opcode
- bus_err  out  1  sticky; set on wait timeout, cleared only by reset

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11.
- Opcodes: 000000 R, 000001 sw, 000010 lw, 000011 addi, 000100 slti, 000101 andi, 000110 ori, 000111 beq, 001000 bne, 001001 jmp.
- op_q is a 6-bit register loaded from op in DECODE. All later states use op_q only.
- All outputs not listed for a state are 0.
- FETCH asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=001.
  - It also asserts ir_write=pc_write=mem_ready and pc_src=00.
  - Next state is DECODE when mem_ready=1. Otherwise it stays in FETCH.
- DECODE asserts alu_src_a=0, alu_src_b=11, alu_op=001, which precomputes the branch target into ALUOut.
  - Next state by op: lw/sw → MEM_ADDR, R → EXEC_R, addi/slti/andi/ori → EXEC_I, beq/bne → BRANCH, jmp → JUMP.
  - Any other op → FETCH with illegal_op=1.
- MEM_ADDR asserts alu_src_a=1, alu_src_b=10, alu_op=001. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD asserts mem_read=1, i_or_d=1. Next state is MEM_WB on mem_ready, otherwise it waits.
- MEM_WB asserts reg_write=1, mem_to_reg=1, reg_dest=0, instr_done=1. Next state is FETCH.
- MEM_WR asserts mem_write=1, i_or_d=1, and instr_done=mem_ready. Next state is FETCH on mem_ready, otherwise it waits.
- EXEC_R asserts alu_src_a=1, alu_src_b=00, alu_op=000. Next state is R_WB.
- R_WB asserts reg_write=1, reg_dest=1, mem_to_reg=0, instr_done=1. Next state is FETCH.
- EXEC_I asserts alu_src_a=1, alu_src_b=10, with alu_op = addi 001, slti 101, andi 011, ori 100. Next state is I_WB.
- I_WB asserts reg_write=1, reg_dest=0, mem_to_reg=0, instr_done=1. Next state is FETCH.
- BRANCH asserts alu_src_a=1, alu_src_b=00, alu_op=010, pc_src=01, instr_done=1. Next state is FETCH.
  - pc_write=(op_q==beq & zero) | (op_q==bne & ~zero). It is combinational on zero.
- JUMP asserts pc_src=10, pc_write=1, instr_done=1. Next state is FETCH.
- Wait counter: a 4-bit wait_cnt increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0. It clears on every state change and whenever mem_ready=1.
- Timeout: if mem_ready=0 and wait_cnt==WAIT_MAX-1, then:
  - bus_err is set.
  - wait_cnt is cleared.
  - The next state is FETCH; this abandons a MEM_RD/MEM_WR, and restarts a FETCH.
  - No reg_write or pc_write is issued for the aborted instruction.
  - instr_done stays 0.
- mem_ready=1 on the same cycle as a timeout: mem_ready wins and the transfer completes normally.

## Timing
- Reset, while rst_n=0 at the edge:
  - Next state is FETCH, with wait_cnt=0, op_q=0, bus_err=0.
  - While rst_n is low, all outputs are combinationally gated to 0: pc_write, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op.
  - state reads 0.
- The first fetch request is in the first cycle with rst_n=1.
- Reset asserted mid-instruction aborts it at the next edge. No write enable is asserted in the reset cycle.
- Latency with zero wait states:
  - R and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne and jmp: 3 cycles.
  - Illegal op: 2 cycles.
- Each mem_ready-low cycle in a memory state adds 1 cycle.
- instr_done is asserted exactly once per retired instruction, on its last cycle; the next cycle is FETCH.

## Test plan
- Reset with rst_n=0 for 2 cycles, then release → state=0, mem_read=1 on the first cycle; all write enables 0 during reset.
- R-type (op=000000), mem_ready=1 → states 0,1,6,7,0; reg_write=1 with reg_dest=1 in state 7; instr_done high only in state 7.
- lw with mem_ready low for 3 cycles in MEM_RD → states 0,1,2,3,3,3,3,4; total 8 cycles; mem_to_reg=1 and reg_write=1 in state 4.
- beq with zero=1 → pc_write=1 and pc_src=01 in BRANCH. bne with zero=1 → pc_write=0. Change op after DECODE → the branch type is unaffected.
- op=111111 → illegal_op pulse in DECODE, return to FETCH, no reg_write; then jmp → pc_write=1, pc_src=10 in state 11.
- WAIT_MAX=8, sw with mem_ready held 0 → 8 cycles in MEM_WR, then bus_err=1 (stays set), FETCH, no instr_done. mem_ready=1 exactly on the 8th wait cycle → normal completion, bus_err stays 0.
